// File: rtl/dram_device_model.sv
// ---------------------------------------------------------------------------
// dram_device_model
//   Cycle-level single-bank DRAM responder for the command interface driven by
//   the DRAM AXI wrapper. Decodes ACT/READ/WRITE/PRE/NOP from CSn/RASn/CASn/WEn,
//   keeps one open-row buffer, enforces tRCD/tRP and returns read data CL
//   cycles after a READ. The memory array is internal and is not reset.
//
//   Optional feature: define DRAM_TIMING_CHECK_EN to make DRAM_err a sticky
//   protocol-violation flag (with a simulation $error per illegal command).
//   Without it, illegal commands are still ignored and DRAM_err is tied 0.
//
// Ports
//   clk         in   clock, all state on rising edge
//   rstn        in   asynchronous active-low reset
//   DRAM_CSn    in   chip select, active low (1 => NOP)
//   DRAM_RASn   in   row strobe, active low
//   DRAM_CASn   in   column strobe, active low
//   DRAM_WEn    in   per-byte write enable, active low
//   DRAM_A      in   row (ACT) or column (READ/WRITE) address
//   DRAM_D      in   write data, sampled with WRITE
//   DRAM_Q      out  read data, held until the next read return
//   DRAM_valid  out  one-cycle pulse, DRAM_Q carries read data
//   DRAM_err    out  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module dram_device_model #(
  parameter int unsigned ROW_BITS = 11,
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned T_RCD    = 5,
  parameter int unsigned T_RP     = 5,
  parameter int unsigned CL       = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  DRAM_CSn,
  input  logic                  DRAM_RASn,
  input  logic                  DRAM_CASn,
  input  logic [DATA_W/8-1:0]   DRAM_WEn,
  input  logic [ROW_BITS-1:0]   DRAM_A,
  input  logic [DATA_W-1:0]     DRAM_D,
  output logic [DATA_W-1:0]     DRAM_Q,
  output logic                  DRAM_valid,
  output logic                  DRAM_err
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned AW     = ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned T_MAX  = (T_MAX0 > 2) ? T_MAX0 : 2;
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_PRECHARGING
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_BITS-1:0] open_row_q, open_row_d;

  // Command decode
  logic we_all1_c, we_all0_c;
  logic is_act_c, is_pre_c, is_rd_c, is_wr_c;
  logic act_ok_c, pre_ok_c, rd_ok_c, wr_ok_c;
  logic [AW-1:0] rw_addr_c;

  assign we_all1_c = &DRAM_WEn;
  assign we_all0_c = ~|DRAM_WEn;
  assign is_act_c  = ~DRAM_CSn & ~DRAM_RASn &  DRAM_CASn & we_all1_c;
  assign is_pre_c  = ~DRAM_CSn & ~DRAM_RASn &  DRAM_CASn & we_all0_c;
  assign is_rd_c   = ~DRAM_CSn &  DRAM_RASn & ~DRAM_CASn & we_all1_c;
  assign is_wr_c   = ~DRAM_CSn &  DRAM_RASn & ~DRAM_CASn & ~we_all1_c;

  // Legality of each command in the current state
  assign act_ok_c = is_act_c & (state_q == ST_IDLE);
  assign pre_ok_c = is_pre_c & ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign rd_ok_c  = is_rd_c  & (state_q == ST_ACTIVE);
  assign wr_ok_c  = is_wr_c  & (state_q == ST_ACTIVE);

  assign rw_addr_c = {open_row_q, DRAM_A[COL_BITS-1:0]};

  // Bank state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      open_row_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      open_row_q <= open_row_d;
    end
  end

  // Next-state logic. The counter is loaded with T-1 on entry so that the
  // command sampled exactly T edges after ACT/PRE already sees the new state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    open_row_d = open_row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (act_ok_c) begin
          open_row_d = DRAM_A;
          if (T_RCD <= 1) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACTIVATING;
            cnt_d   = CNT_W'(T_RCD - 1);
          end
        end else if (pre_ok_c) begin
          if (T_RP <= 1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_PRECHARGING;
            cnt_d   = CNT_W'(T_RP - 1);
          end
        end
      end
      ST_ACTIVATING: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (pre_ok_c) begin
          if (T_RP <= 1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_PRECHARGING;
            cnt_d   = CNT_W'(T_RP - 1);
          end
        end
      end
      ST_PRECHARGING: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory array with byte-lane writes; contents survive reset
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (!DRAM_WEn[i]) begin
          mem[rw_addr_c][i*8 +: 8] <= DRAM_D[i*8 +: 8];
        end
      end
    end
  end

  // CL-deep read return pipeline; stage 0 captures the array at the READ edge
  logic [CL-1:0]     rd_vld_q;
  logic [DATA_W-1:0] rd_dat_q [CL];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q   <= '0;
      for (int unsigned i = 0; i < CL; i++) begin
        rd_dat_q[i] <= '0;
      end
      DRAM_valid <= 1'b0;
      DRAM_Q     <= '0;
    end else begin
      rd_vld_q[0] <= rd_ok_c;
      if (rd_ok_c) begin
        rd_dat_q[0] <= mem[rw_addr_c];
      end
      for (int unsigned i = 1; i < CL; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
      DRAM_valid <= rd_vld_q[CL-1];
      if (rd_vld_q[CL-1]) begin
        DRAM_Q <= rd_dat_q[CL-1];
      end
    end
  end

`ifdef DRAM_TIMING_CHECK_EN
  // Any selected command that is not legal in the current state
  logic cmd_illegal_c;
  assign cmd_illegal_c = ~DRAM_CSn & ~(act_ok_c | pre_ok_c | rd_ok_c | wr_ok_c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      DRAM_err <= 1'b0;
    end else if (cmd_illegal_c) begin
      DRAM_err <= 1'b1;
      $error("%0t dram_device_model: illegal command rasn=%b casn=%b wen=%b a=%h in state %s",
             $time, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, state_q.name());
    end
  end
`else
  assign DRAM_err = 1'b0;
`endif

endmodule
